// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Front-end stage driving the fetch port of the unified memory. It owns the
//   program counter, pulses fetch with the PC on fetch_addr, captures the
//   memory's registered outputs one cycle later into an instruction bundle and
//   holds that bundle for execute under a valid/ready handshake. Absolute and
//   PC-relative redirects are taken when execute accepts the bundle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   stall               freeze issue of new fetches
//   fetch, fetch_addr   one-cycle fetch strobe and instruction address (PC)
//   mem_*               registered memory outputs (instr, imm, imm2, data,
//                       edge weight, sp_node)
//   *_q, pc_q           captured bundle and the PC it was fetched from
//   valid, ready        bundle handshake with execute
//   instr_len           word length of the held instruction (0 treated as 1)
//   redirect,
//   redirect_rel,
//   redirect_addr       jump request: absolute target or signed PC offset
//   fetch_count         number of bundles accepted since reset (wraps)

module fetch_sequencer #(
  parameter int              WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  output logic             fetch,
  output logic [WORD-1:0]  fetch_addr,
  input  logic [WORD-1:0]  mem_instr,
  input  logic [WORD-1:0]  mem_imm,
  input  logic [WORD-1:0]  mem_imm2,
  input  logic [WORD-1:0]  mem_data,
  input  logic [WORD-1:0]  mem_weight,
  input  logic [WORD-1:0]  mem_sp_node,
  output logic [WORD-1:0]  instr_q,
  output logic [WORD-1:0]  imm_q,
  output logic [WORD-1:0]  imm2_q,
  output logic [WORD-1:0]  data_q,
  output logic [WORD-1:0]  weight_q,
  output logic [WORD-1:0]  sp_node_q,
  output logic [WORD-1:0]  pc_q,
  output logic             valid,
  input  logic             ready,
  input  logic [1:0]       instr_len,
  input  logic             redirect,
  input  logic             redirect_rel,
  input  logic [WORD-1:0]  redirect_addr,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          state;
  logic [WORD-1:0] pc;
  logic [1:0]      len_eff;
  logic [WORD-1:0] seq_pc;
  logic [WORD-1:0] next_pc;
  logic            accept;

  // Next-PC selection for the bundle being accepted. A zero length is
  // promoted to one word so a bad decode can never stall the PC in place.
  // All arithmetic wraps modulo 2^WORD; the relative offset is two's
  // complement, so a plain add handles both directions.
  always_comb begin
    len_eff = (instr_len == 2'd0) ? 2'd1 : instr_len;
    seq_pc  = pc_q + {{(WORD-2){1'b0}}, len_eff};
    next_pc = seq_pc;
    if (redirect) begin
      next_pc = redirect_rel ? (pc_q + redirect_addr) : redirect_addr;
    end
  end

  assign accept = (state == HOLD) && ready;

  // The strobe must react to stall in the same cycle, so it is decoded from
  // the registered state. Gating with rst_n keeps the memory idle while reset
  // is held, even though the state already sits in ISSUE.
  assign fetch      = rst_n && !stall && (state == ISSUE);
  assign fetch_addr = pc;

  // Sequencer: ISSUE -> CAPTURE -> HOLD -> ISSUE. The memory samples the
  // fetch on the edge leaving ISSUE and presents its outputs during CAPTURE,
  // so the bundle is latched on the edge leaving CAPTURE. Reset abandons any
  // fetch in flight; its memory outputs are never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ISSUE;
      pc          <= RESET_PC;
      valid       <= 1'b0;
      fetch_count <= '0;
      instr_q     <= '0;
      imm_q       <= '0;
      imm2_q      <= '0;
      data_q      <= '0;
      weight_q    <= '0;
      sp_node_q   <= '0;
      pc_q        <= '0;
    end else begin
      case (state)
        ISSUE: begin
          if (!stall) begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          instr_q   <= mem_instr;
          imm_q     <= mem_imm;
          imm2_q    <= mem_imm2;
          data_q    <= mem_data;
          weight_q  <= mem_weight;
          sp_node_q <= mem_sp_node;
          pc_q      <= pc;
          valid     <= 1'b1;
          state     <= HOLD;
        end

        HOLD: begin
          if (accept) begin
            fetch_count <= fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
            pc          <= next_pc;
            valid       <= 1'b0;
            state       <= ISSUE;
          end
        end

        default: begin
          state <= ISSUE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Drives fetch_sequencer against a behavioural memory with one-cycle
//   registered outputs. A table of bundles walks sequential fetch, absolute
//   and relative jumps, address wrap and zero length; hand-written sequences
//   cover backpressure, stall and asynchronous reset during CAPTURE.

module tb_fetch_sequencer;

  localparam int WORD  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic             fetch;
  logic [WORD-1:0]  fetch_addr;
  logic [WORD-1:0]  mem_instr = '0;
  logic [WORD-1:0]  mem_imm = '0;
  logic [WORD-1:0]  mem_imm2 = '0;
  logic [WORD-1:0]  mem_data = '0;
  logic [WORD-1:0]  mem_weight = '0;
  logic [WORD-1:0]  mem_sp_node = '0;
  logic [WORD-1:0]  instr_q, imm_q, imm2_q, data_q, weight_q, sp_node_q, pc_q;
  logic             valid;
  logic             ready = 1'b0;
  logic [1:0]       instr_len = 2'd0;
  logic             redirect = 1'b0;
  logic             redirect_rel = 1'b0;
  logic [WORD-1:0]  redirect_addr = '0;
  logic [CNT_W-1:0] fetch_count;
  logic             noise = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.WORD(WORD), .RESET_PC('0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .fetch(fetch), .fetch_addr(fetch_addr),
    .mem_instr(mem_instr), .mem_imm(mem_imm), .mem_imm2(mem_imm2),
    .mem_data(mem_data), .mem_weight(mem_weight), .mem_sp_node(mem_sp_node),
    .instr_q(instr_q), .imm_q(imm_q), .imm2_q(imm2_q), .data_q(data_q),
    .weight_q(weight_q), .sp_node_q(sp_node_q), .pc_q(pc_q),
    .valid(valid), .ready(ready), .instr_len(instr_len),
    .redirect(redirect), .redirect_rel(redirect_rel),
    .redirect_addr(redirect_addr), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory contents: an odd-multiplier hash, distinct for every address.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Memory model: registered outputs updated on the edge that sees fetch.
  // With noise set the outputs churn while no fetch is pending.
  always @(posedge clk) begin
    if (fetch) begin
      mem_instr   <= mem_read(fetch_addr);
      mem_imm     <= mem_read(fetch_addr + 32'd1);
      mem_imm2    <= mem_read(fetch_addr + 32'd2);
      mem_data    <= mem_read(mem_read(fetch_addr + 32'd1));
      mem_weight  <= mem_read(fetch_addr) ^ 32'h00FF_00FF;
      mem_sp_node <= mem_read(fetch_addr + 32'h1000);
    end else if (noise) begin
      mem_instr   <= $urandom;
      mem_imm     <= $urandom;
      mem_imm2    <= $urandom;
      mem_data    <= $urandom;
      mem_weight  <= $urandom;
      mem_sp_node <= $urandom;
    end
  end

  typedef struct {
    logic [31:0] exp_pc;
    logic [1:0]  len;
    logic        redir;
    logic        rel;
    logic [31:0] raddr;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic rd,
                               input logic rl, input logic [31:0] ra,
                               input logic [1:0] len);
    stall         = s;
    ready         = r;
    redirect      = rd;
    redirect_rel  = rl;
    redirect_addr = ra;
    instr_len     = len;
  endtask

  task automatic checkBundle(input string tag, input logic [31:0] a);
    checkOutput({tag, "_pc_q"}, pc_q, a);
    checkOutput({tag, "_instr_q"}, instr_q, mem_read(a));
    checkOutput({tag, "_imm_q"}, imm_q, mem_read(a + 32'd1));
    checkOutput({tag, "_imm2_q"}, imm2_q, mem_read(a + 32'd2));
    checkOutput({tag, "_data_q"}, data_q, mem_read(mem_read(a + 32'd1)));
    checkOutput({tag, "_weight_q"}, weight_q, mem_read(a) ^ 32'h00FF_00FF);
    checkOutput({tag, "_sp_node_q"}, sp_node_q, mem_read(a + 32'h1000));
  endtask

  // Waits (bounded) for valid; the number of negedges taken must be two.
  task automatic waitValid(input string tag);
    int cycles;
    cycles = 0;
    while (!valid && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd2);
  endtask

  initial begin
    //             exp_pc        len   redir rel   raddr          exp_next
    vecs[0]  = '{32'h0,        2'd2, 1'b0, 1'b0, 32'h0,        32'h2};
    vecs[1]  = '{32'h2,        2'd2, 1'b0, 1'b0, 32'h0,        32'h4};
    vecs[2]  = '{32'h4,        2'd2, 1'b0, 1'b0, 32'h0,        32'h6};
    vecs[3]  = '{32'h6,        2'd2, 1'b1, 1'b0, 32'h9,        32'h9};
    vecs[4]  = '{32'h9,        2'd1, 1'b0, 1'b0, 32'h0,        32'hA};
    vecs[5]  = '{32'hA,        2'd0, 1'b0, 1'b0, 32'h0,        32'hB};
    vecs[6]  = '{32'hB,        2'd3, 1'b1, 1'b0, 32'h6,        32'h6};
    vecs[7]  = '{32'h6,        2'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'h3};
    vecs[8]  = '{32'h3,        2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[9]  = '{32'hFFFF_FFFF, 2'd2, 1'b0, 1'b0, 32'h0,        32'h1};
    vecs[10] = '{32'h1,        2'd3, 1'b0, 1'b0, 32'h0,        32'h4};
    vecs[11] = '{32'h4,        2'd1, 1'b1, 1'b1, 32'h10,       32'h14};

    // Reset state while rst_n is held low.
    repeat (3) @(negedge clk);
    checkOutput("rst_fetch", 32'(fetch), 32'd0);
    checkOutput("rst_valid", 32'(valid), 32'd0);
    checkOutput("rst_count", 32'(fetch_count), 32'd0);
    checkOutput("rst_fetch_addr", fetch_addr, 32'h0);
    checkOutput("rst_instr_q", instr_q, 32'h0);
    checkOutput("rst_pc_q", pc_q, 32'h0);

    rst_n = 1'b1;
    #1;
    checkOutput("first_fetch", 32'(fetch), 32'd1);
    checkOutput("first_fetch_addr", fetch_addr, 32'h0);

    // Table-driven bundles: check the held bundle, accept with the row's
    // controls, then check the next issue.
    for (int i = 0; i < 12; i++) begin
      waitValid($sformatf("v%0d", i));
      checkBundle($sformatf("v%0d", i), vecs[i].exp_pc);
      checkOutput($sformatf("v%0d_hold_fetch", i), 32'(fetch), 32'd0);
      applyStimulus(1'b0, 1'b1, vecs[i].redir, vecs[i].rel, vecs[i].raddr,
                    vecs[i].len);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid_drop", i), 32'(valid), 32'd0);
      checkOutput($sformatf("v%0d_issue_fetch", i), 32'(fetch), 32'd1);
      checkOutput($sformatf("v%0d_next_addr", i), fetch_addr, vecs[i].exp_next);
      checkOutput($sformatf("v%0d_count", i), 32'(fetch_count), i + 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    end

    // Backpressure: five cycles without ready while memory outputs churn.
    waitValid("bp");
    checkBundle("bp", 32'h14);
    noise = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_valid", k), 32'(valid), 32'd1);
      checkOutput($sformatf("bp%0d_instr_q", k), instr_q, mem_read(32'h14));
      checkOutput($sformatf("bp%0d_pc_q", k), pc_q, 32'h14);
      checkOutput($sformatf("bp%0d_fetch", k), 32'(fetch), 32'd0);
    end
    noise = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd2);
    @(negedge clk);
    checkOutput("bp_next_addr", fetch_addr, 32'h16);
    checkOutput("bp_count", 32'(fetch_count), 32'd13);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);

    // Stall with accept in HOLD and zero length, then four stalled cycles.
    waitValid("st");
    checkBundle("st", 32'h16);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0);
    @(negedge clk);
    checkOutput("st_valid", 32'(valid), 32'd0);
    checkOutput("st_count", 32'(fetch_count), 32'd14);
    checkOutput("st_addr", fetch_addr, 32'h17);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("st%0d_fetch", k), 32'(fetch), 32'd0);
      checkOutput($sformatf("st%0d_addr", k), fetch_addr, 32'h17);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    #1;
    checkOutput("st_release_fetch", 32'(fetch), 32'd1);
    @(negedge clk);
    checkOutput("cap_fetch", 32'(fetch), 32'd0);
    checkOutput("cap_valid", 32'(valid), 32'd0);

    // Asynchronous reset in CAPTURE: the fetch from 0x17 is abandoned.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(valid), 32'd0);
    checkOutput("arst_fetch", 32'(fetch), 32'd0);
    checkOutput("arst_count", 32'(fetch_count), 32'd0);
    checkOutput("arst_addr", fetch_addr, 32'h0);
    checkOutput("arst_pc_q", pc_q, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("arst_held_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("arst_first_fetch", 32'(fetch), 32'd1);
    checkOutput("arst_first_addr", fetch_addr, 32'h0);
    waitValid("ar");
    checkBundle("ar", 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd1);
    @(negedge clk);
    checkOutput("ar_count", 32'(fetch_count), 32'd1);
    checkOutput("ar_next_addr", fetch_addr, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always reaches its summary.
  initial begin
    #20000;
    errors++;
    $display("[TB] FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
